// File: rtl/proc_pkg.sv
// Definitions shared by the instruction sequencer and the processor top:
// opcodes, instruction word field positions, operand type flags and sequencer states.
package proc_pkg;

  localparam int unsigned DEF_MINDW = 12;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_BRA = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_ROT = 4'd6;
  localparam logic [3:0] OP_SHF = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 28;
  localparam int unsigned IMM_BIT  = 27;
  localparam int unsigned COND_MSB = 26;
  localparam int unsigned COND_LSB = 24;
  localparam int unsigned SRC_MSB  = 23;
  localparam int unsigned SRC_LSB  = 12;
  localparam int unsigned DST_MSB  = 11;
  localparam int unsigned DST_LSB  = 0;
  localparam int unsigned FIELDW   = 12;
  localparam int unsigned CONDW    = 3;

  localparam logic REGTYPE = 1'b0;
  localparam logic IMMTYPE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StIssue,
    StHalted
  } seq_state_e;

  // Opcodes 10-15 decode to NOP.
  function automatic logic [3:0] legal_op(input logic [3:0] op);
    return (op <= OP_CMP) ? op : OP_NOP;
  endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Bundle between the sequencer, program memory and processor: control, fetch bus and
// decoded instruction outputs.
interface instr_seq_if
  import proc_pkg::*;
#(
  parameter int unsigned BUSW  = 32,
  parameter int unsigned PSRW  = 5,
  parameter int unsigned MINDW = DEF_MINDW
);

  logic             start;
  logic [MINDW-1:0] start_pc;
  logic [MINDW-1:0] pm_addr;
  logic [31:0]      pm_data;
  logic [PSRW-1:0]  Status;
  logic [3:0]       Opcode;
  logic [BUSW-1:0]  DstOp;
  logic [BUSW-1:0]  SrcOp;
  logic             srcIsImm;
  logic             issue_valid;
  logic             busy;
  logic             halted;
  logic [MINDW-1:0] pc;

  modport master (
    input  start, start_pc, pm_data, Status,
    output pm_addr, Opcode, DstOp, SrcOp, srcIsImm, issue_valid, busy, halted, pc
  );

  modport slave (
    output start, start_pc, pm_data, Status,
    input  pm_addr, Opcode, DstOp, SrcOp, srcIsImm, issue_valid, busy, halted, pc
  );

endinterface

// File: rtl/instr_seq_br_eval.sv
// Branch condition evaluator: cond 0 is unconditional, cond 1..PSRW tests
// Status[cond-1], anything larger is never taken.
module instr_seq_br_eval
  import proc_pkg::*;
#(
  parameter int unsigned PSRW = 5
) (
  input  logic [CONDW-1:0] cond,
  input  logic [PSRW-1:0]  Status,
  output logic             taken
);

  always_comb begin
    taken = (cond == '0);
    for (int unsigned i = 0; i < PSRW; i++) begin
      if (32'(cond) == i + 1) taken = Status[i];
    end
  end

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches a word, decodes it onto the processor inputs, holds it
// for EXEC_CYC cycles, then advances or branches; stops on HLT.
module instr_seq
  import proc_pkg::*;
#(
  parameter int unsigned BUSW     = 32,
  parameter int unsigned PSRW     = 5,
  parameter int unsigned MINDW    = DEF_MINDW,
  parameter int unsigned EXEC_CYC = 4
) (
  input logic         clk,
  input logic         rst_n,
  instr_seq_if.master bus
);

  localparam int unsigned CNTW = $clog2(EXEC_CYC);

  seq_state_e       state_q;
  logic [MINDW-1:0] pc_q, pm_addr_q, pc_next;
  logic [3:0]       opcode_q, word_op;
  logic [FIELDW-1:0] dst_q, src_q;
  logic [CONDW-1:0] cond_q, word_cond;
  logic             imm_q, issue_valid_q, busy_q, halted_q;
  logic [CNTW-1:0]  cnt_q;
  logic             br_taken;

  assign word_op   = bus.pm_data[OP_MSB:OP_LSB];
  assign word_cond = bus.pm_data[COND_MSB:COND_LSB];

  instr_seq_br_eval #(
    .PSRW (PSRW)
  ) u_br_eval (
    .cond   (cond_q),
    .Status (bus.Status),
    .taken  (br_taken)
  );

  // Status is live here, so the branch resolves on the last ISSUE cycle.
  always_comb begin
    pc_next = pc_q + MINDW'(1);
    if (opcode_q == OP_BRA && br_taken) pc_next = MINDW'(dst_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      pm_addr_q     <= '0;
      opcode_q      <= OP_NOP;
      dst_q         <= '0;
      src_q         <= '0;
      cond_q        <= '0;
      imm_q         <= REGTYPE;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHalted: begin
          if (bus.start) begin
            pc_q      <= bus.start_pc;
            pm_addr_q <= bus.start_pc;
            busy_q    <= 1'b1;
            halted_q  <= 1'b0;
            state_q   <= StFetch;
          end
        end
        StFetch: state_q <= StWait;
        StWait: begin
          opcode_q <= legal_op(word_op);
          dst_q    <= bus.pm_data[DST_MSB:DST_LSB];
          cond_q   <= word_cond;
          if (word_op == OP_BRA) begin
            src_q <= FIELDW'(word_cond);
            imm_q <= REGTYPE;
          end else begin
            src_q <= bus.pm_data[SRC_MSB:SRC_LSB];
            imm_q <= bus.pm_data[IMM_BIT];
          end
          if (word_op == OP_HLT) begin
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= StHalted;
          end else begin
            cnt_q         <= CNTW'(EXEC_CYC - 1);
            issue_valid_q <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          if (cnt_q == '0) begin
            issue_valid_q <= 1'b0;
            pc_q          <= pc_next;
            pm_addr_q     <= pc_next;
            state_q       <= StFetch;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pm_addr     = pm_addr_q;
  assign bus.pc          = pc_q;
  assign bus.Opcode      = opcode_q;
  assign bus.DstOp       = BUSW'(dst_q);
  assign bus.SrcOp       = BUSW'(src_q);
  assign bus.srcIsImm    = imm_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq with a synchronous program memory model.
module tb_instr_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem [0:4095];

  instr_seq_if bus ();

  instr_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.pm_data <= mem[bus.pm_addr];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic imm,
                                      input logic [2:0] cond, input logic [11:0] src,
                                      input logic [11:0] dst);
    return {op, imm, cond, src, dst};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [11:0] addr);
    bus.start    = 1'b1;
    bus.start_pc = addr;
    tick(1);
    bus.start = 1'b0;
  endtask

  // Runs one non-HLT instruction from IDLE and checks the next fetch address.
  task automatic run_one(input string tag, input logic [11:0] addr, input logic [31:0] word,
                         input logic [4:0] status, input logic [11:0] exp_next);
    do_reset();
    mem[addr]  = word;
    bus.Status = status;
    pulse_start(addr);
    tick(6);
    chk(tag, 64'(bus.pm_addr), 64'(exp_next));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus.start    = 1'b0;
    bus.start_pc = '0;
    bus.Status   = '0;
    tick(2);
    chk("rst_opcode", 64'(bus.Opcode), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_halted", 64'(bus.halted), 64'h0);
    chk("rst_valid", 64'(bus.issue_valid), 64'h0);
    chk("rst_pc", 64'(bus.pc), 64'h0);
    chk("rst_pm_addr", 64'(bus.pm_addr), 64'h0);
    chk("rst_ops", {bus.DstOp, bus.SrcOp}, 64'h0);
    rst_n = 1'b1;

    // Straight line: ADD imm, XOR reg, HLT.
    mem[0] = enc(4'd5, 1'b1, 3'd0, 12'd5, 12'd3);
    mem[1] = enc(4'd4, 1'b0, 3'd0, 12'd2, 12'd3);
    mem[2] = enc(4'd8, 1'b0, 3'd0, 12'd0, 12'd0);
    pulse_start(12'd0);
    chk("sl_busy", 64'(bus.busy), 64'h1);
    tick(1);
    chk("sl_wait_valid", 64'(bus.issue_valid), 64'h0);
    tick(1);
    chk("sl_add_op", 64'(bus.Opcode), 64'h5);
    chk("sl_add_src", 64'(bus.SrcOp), 64'h5);
    chk("sl_add_dst", 64'(bus.DstOp), 64'h3);
    chk("sl_add_imm", 64'(bus.srcIsImm), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("sl_add_hold", {bus.issue_valid, bus.Opcode}, {1'b1, 4'h5});
    end
    tick(1);
    chk("sl_add_end", {bus.issue_valid, bus.pm_addr}, {1'b0, 12'd1});
    tick(2);
    chk("sl_xor_op", 64'(bus.Opcode), 64'h4);
    chk("sl_xor_src", {bus.srcIsImm, bus.SrcOp}, {1'b0, 32'd2});
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("sl_xor_hold", {bus.issue_valid, bus.Opcode}, {1'b1, 4'h4});
    end
    tick(1);
    chk("sl_xor_end", {bus.issue_valid, bus.pm_addr}, {1'b0, 12'd2});
    tick(1);
    chk("sl_pre_halt", 64'(bus.halted), 64'h0);
    tick(1);
    chk("sl_halted", {bus.halted, bus.busy, bus.issue_valid}, {1'b1, 1'b0, 1'b0});
    chk("sl_hlt_op", 64'(bus.Opcode), 64'h8);

    // Restart from HALTED into a taken BRA; a start while busy is ignored.
    mem[12'h010] = enc(4'd3, 1'b1, 3'd1, 12'hABC, 12'h020);
    bus.Status   = 5'b00001;
    pulse_start(12'h010);
    chk("rs_halted", {bus.halted, bus.busy}, {1'b0, 1'b1});
    chk("rs_fetch", 64'(bus.pm_addr), 64'h010);
    bus.start    = 1'b1;
    bus.start_pc = 12'h333;
    tick(1);
    bus.start = 1'b0;
    chk("busy_start_pc", 64'(bus.pc), 64'h010);
    tick(1);
    chk("bra_op", 64'(bus.Opcode), 64'h3);
    chk("bra_src", {bus.srcIsImm, bus.SrcOp}, {1'b0, 32'd1});
    chk("bra_dst", 64'(bus.DstOp), 64'h020);
    tick(4);
    chk("bra_taken", 64'(bus.pm_addr), 64'h020);
    chk("bra_taken_pc", 64'(bus.pc), 64'h020);

    run_one("bra_not_taken", 12'd7, enc(4'd3, 1'b0, 3'd1, 12'd0, 12'h020), 5'b00000, 12'd8);
    run_one("bra_cond6", 12'h030, enc(4'd3, 1'b0, 3'd6, 12'd0, 12'h100), 5'b11111, 12'h031);
    run_one("bra_cond7", 12'h040, enc(4'd3, 1'b0, 3'd7, 12'd0, 12'h100), 5'b11111, 12'h041);
    run_one("bra_cond5", 12'h050, enc(4'd3, 1'b0, 3'd5, 12'd0, 12'h123), 5'b10000, 12'h123);
    run_one("bra_cond5_nt", 12'h058, enc(4'd3, 1'b0, 3'd5, 12'd0, 12'h123), 5'b01111, 12'h059);
    run_one("bra_cond0", 12'h060, enc(4'd3, 1'b0, 3'd0, 12'd0, 12'h200), 5'b00000, 12'h200);
    run_one("wrap", 12'hFFF, 32'h0, 5'b00000, 12'h000);
    chk("wrap_pc", 64'(bus.pc), 64'h0);

    // Unimplemented opcode executes as NOP.
    do_reset();
    mem[12'h070] = enc(4'hF, 1'b1, 3'd0, 12'h012, 12'h034);
    pulse_start(12'h070);
    tick(2);
    chk("opF_nop", {bus.issue_valid, bus.Opcode}, {1'b1, 4'h0});
    tick(4);
    chk("opF_next", 64'(bus.pm_addr), 64'h071);

    // Asynchronous reset in the middle of ISSUE.
    do_reset();
    mem[12'h080] = enc(4'd5, 1'b1, 3'd0, 12'h0FF, 12'h0AA);
    pulse_start(12'h080);
    tick(3);
    chk("mid_pre", {bus.issue_valid, bus.Opcode}, {1'b1, 4'h5});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {bus.issue_valid, bus.busy, bus.halted}, 3'b000);
    chk("mid_rst_op", {bus.Opcode, bus.srcIsImm}, 5'b0);
    chk("mid_rst_ops", {bus.DstOp, bus.SrcOp}, 64'h0);
    chk("mid_rst_pc", {bus.pc, bus.pm_addr}, 24'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("mid_rst_idle", {bus.busy, bus.pm_addr}, {1'b0, 12'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
